// File: rtl/ldst_seq_pkg.sv
// Shared constants and state encoding for the ld/ldi/st control sequencer.
package ldst_seq_pkg;

    // Opcodes as they appear in IR[31:27]
    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_LDI = 5'b00001;
    localparam logic [4:0] OP_ST  = 5'b00010;

    // Step value reported while no instruction is in flight
    localparam logic [3:0] STEP_IDLE = 4'hF;

    // Wait counter width: large enough for wait counts 0..15
    localparam int WAIT_W = $clog2(16);

    // State encoding doubles as the step monitor value
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_IDLE = 4'hF
    } state_t;

endpackage

// File: rtl/ldst_control_seq_timer.sv
// Memory wait-state timer, shared by every step that holds Read or Write.
// Loaded with MEM_WAIT as a memory step is entered; the step ends when
// the count has run down to zero.
module mem_wait_timer
    import ldst_seq_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    output logic              expired,
    output logic [WAIT_W-1:0] count
);

    // Down-counter: load on step entry, then count down and hold at zero
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= WAIT_W'(MEM_WAIT);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ldst_control_seq.sv
// Control sequencer for fetch + ld / ldi / st. Steps T0..T7 drive the
// Datapath strobes directly; memory steps are stretched by MEM_WAIT cycles.
module ldst_control_seq
    import ldst_seq_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int OP_W     = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [OP_W-1:0] ir_opcode,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            Zin,
    output logic            Zlowout,
    output logic            PCin,
    output logic            Read,
    output logic            Write,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            BAout,
    output logic            Yin,
    output logic            ADD,
    output logic            Rin,
    output logic            Rout,
    output logic            Gra,
    output logic            Grb,
    output logic            Cout,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [3:0]      step
);

    state_t            state_reg;
    state_t            state_next;
    logic [OP_W-1:0]   op_reg;
    logic              timer_load;
    logic              timer_expired;
    logic [WAIT_W-1:0] timer_count;

    // Opcode classes: the live IR field decides legality in T3, the
    // latched copy steers T5..T7.
    logic op_live_legal;
    logic op_is_ldi;
    logic op_is_st;

    assign op_live_legal = (ir_opcode == OP_W'(OP_LD))  ||
                           (ir_opcode == OP_W'(OP_LDI)) ||
                           (ir_opcode == OP_W'(OP_ST));
    assign op_is_ldi     = (op_reg == OP_W'(OP_LDI));
    assign op_is_st      = (op_reg == OP_W'(OP_ST));

    mem_wait_timer #(
        .MEM_WAIT (MEM_WAIT)
    ) u_timer (
        .clk     (clk),
        .clr     (clr),
        .load    (timer_load),
        .expired (timer_expired),
        .count   (timer_count)
    );

    // State register; clr drops straight back to IDLE with no completion
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Opcode latch, captured while IR is presented in T3
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_reg <= '0;
        end else if (state_reg == S_T3) begin
            op_reg <= ir_opcode;
        end
    end

    // Next-state logic and wait-timer load on entry to memory steps
    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_T0;
                end
            end
            S_T0: begin
                state_next = S_T1;
                timer_load = 1'b1;
            end
            S_T1: begin
                if (timer_expired) begin
                    state_next = S_T2;
                end
            end
            S_T2: begin
                state_next = S_T3;
            end
            S_T3: begin
                state_next = op_live_legal ? S_T4 : S_IDLE;
            end
            S_T4: begin
                state_next = S_T5;
            end
            S_T5: begin
                if (op_is_ldi) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_T6;
                    // ld reads memory in T6; st only loads MDR there
                    timer_load = !op_is_st;
                end
            end
            S_T6: begin
                if (op_is_st) begin
                    state_next = S_T7;
                    timer_load = 1'b1;
                end else if (timer_expired) begin
                    state_next = S_T7;
                end
            end
            S_T7: begin
                if (!op_is_st || timer_expired) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Strobe decode from the registered state and wait count. The only
    // live-input term is illegal, which must flag the IR seen in T3.
    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        BAout   = 1'b0;
        Yin     = 1'b0;
        ADD     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Cout    = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_reg)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
            end
            S_T1: begin
                // PC advances once, on the first cycle of the fetch read
                IncPC = (timer_count == WAIT_W'(MEM_WAIT));
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Grb     = 1'b1;
                BAout   = 1'b1;
                Yin     = 1'b1;
                illegal = !op_live_legal;
            end
            S_T4: begin
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (op_is_ldi) begin
                    Gra  = 1'b1;
                    Rin  = 1'b1;
                    done = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (op_is_st) begin
                    Gra   = 1'b1;
                    BAout = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_T7: begin
                MDRout = 1'b1;
                if (op_is_st) begin
                    Write = 1'b1;
                    done  = timer_expired;
                end else begin
                    Gra  = 1'b1;
                    Rin  = 1'b1;
                    done = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_reg != S_IDLE);
    assign step = state_reg;

endmodule

// File: tb/tb_ldst_control_seq.sv
// Scoreboard bench for ldst_control_seq: two instances (MEM_WAIT 0 and 2).
// Stimulus pushes the expected per-cycle strobe vectors; a monitor pops and
// compares every cycle in which a DUT shows any activity.
module tb_ldst_control_seq;
    import ldst_seq_pkg::*;

    // Strobe vector layout used for both DUTs
    localparam logic [21:0] M_PCOUT   = 22'h200000;
    localparam logic [21:0] M_MARIN   = 22'h100000;
    localparam logic [21:0] M_INCPC   = 22'h080000;
    localparam logic [21:0] M_ZIN     = 22'h040000;
    localparam logic [21:0] M_ZLOWOUT = 22'h020000;
    localparam logic [21:0] M_READ    = 22'h008000;
    localparam logic [21:0] M_WRITE   = 22'h004000;
    localparam logic [21:0] M_MDRIN   = 22'h002000;
    localparam logic [21:0] M_MDROUT  = 22'h001000;
    localparam logic [21:0] M_IRIN    = 22'h000800;
    localparam logic [21:0] M_BAOUT   = 22'h000400;
    localparam logic [21:0] M_YIN     = 22'h000200;
    localparam logic [21:0] M_ADD     = 22'h000100;
    localparam logic [21:0] M_RIN     = 22'h000080;
    localparam logic [21:0] M_GRA     = 22'h000020;
    localparam logic [21:0] M_GRB     = 22'h000010;
    localparam logic [21:0] M_COUT    = 22'h000008;
    localparam logic [21:0] M_BUSY    = 22'h000004;
    localparam logic [21:0] M_DONE    = 22'h000002;
    localparam logic [21:0] M_ILL     = 22'h000001;

    typedef struct {
        logic [3:0]  step;
        logic [21:0] sig;
        int          cyc;
    } exp_t;

    logic       clk;
    logic       clr;
    logic       start0, start1;
    logic [4:0] op0, op1;
    wire [21:0] sig0, sig1;
    wire [3:0]  step0, step1;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   done_cyc[2];
    int   done_cnt[2];
    int   ill_cyc[2];
    int   rd_cnt[2];
    int   inc_cnt[2];
    int   rin_cnt[2];

    ldst_control_seq #(.MEM_WAIT(0), .OP_W(5)) dut0 (
        .clk(clk), .clr(clr), .start(start0), .ir_opcode(op0),
        .PCout(sig0[21]), .MARin(sig0[20]), .IncPC(sig0[19]), .Zin(sig0[18]),
        .Zlowout(sig0[17]), .PCin(sig0[16]), .Read(sig0[15]), .Write(sig0[14]),
        .MDRin(sig0[13]), .MDRout(sig0[12]), .IRin(sig0[11]), .BAout(sig0[10]),
        .Yin(sig0[9]), .ADD(sig0[8]), .Rin(sig0[7]), .Rout(sig0[6]),
        .Gra(sig0[5]), .Grb(sig0[4]), .Cout(sig0[3]), .busy(sig0[2]),
        .done(sig0[1]), .illegal(sig0[0]), .step(step0)
    );

    ldst_control_seq #(.MEM_WAIT(2), .OP_W(5)) dut1 (
        .clk(clk), .clr(clr), .start(start1), .ir_opcode(op1),
        .PCout(sig1[21]), .MARin(sig1[20]), .IncPC(sig1[19]), .Zin(sig1[18]),
        .Zlowout(sig1[17]), .PCin(sig1[16]), .Read(sig1[15]), .Write(sig1[14]),
        .MDRin(sig1[13]), .MDRout(sig1[12]), .IRin(sig1[11]), .BAout(sig1[10]),
        .Yin(sig1[9]), .ADD(sig1[8]), .Rin(sig1[7]), .Rout(sig1[6]),
        .Gra(sig1[5]), .Grb(sig1[4]), .Cout(sig1[3]), .busy(sig1[2]),
        .done(sig1[1]), .illegal(sig1[0]), .step(step1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int idx, input logic [3:0] st, input logic [21:0] s, input int c);
        exp_t e;
        e.step = st;
        e.sig  = s;
        e.cyc  = c;
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // Expected per-cycle vectors for one instruction whose start is sampled
    // at the end of cycle 'base'.
    task automatic push_instr(input int idx, input logic [4:0] op, input int w, input int base);
        int   c;
        logic is_ld, is_ldi, is_st;
        c      = base;
        is_ld  = (op == OP_LD);
        is_ldi = (op == OP_LDI);
        is_st  = (op == OP_ST);
        c++; push(idx, 4'd0, M_PCOUT | M_MARIN | M_BUSY, c);
        for (int i = 0; i <= w; i++) begin
            c++; push(idx, 4'd1, M_READ | M_MDRIN | M_BUSY | ((i == 0) ? M_INCPC : 22'h0), c);
        end
        c++; push(idx, 4'd2, M_MDROUT | M_IRIN | M_BUSY, c);
        c++;
        if (!(is_ld || is_ldi || is_st)) begin
            push(idx, 4'd3, M_GRB | M_BAOUT | M_YIN | M_BUSY | M_ILL, c);
            return;
        end
        push(idx, 4'd3, M_GRB | M_BAOUT | M_YIN | M_BUSY, c);
        c++; push(idx, 4'd4, M_COUT | M_ADD | M_ZIN | M_BUSY, c);
        c++;
        if (is_ldi) begin
            push(idx, 4'd5, M_ZLOWOUT | M_GRA | M_RIN | M_DONE | M_BUSY, c);
            return;
        end
        push(idx, 4'd5, M_ZLOWOUT | M_MARIN | M_BUSY, c);
        if (is_ld) begin
            for (int i = 0; i <= w; i++) begin
                c++; push(idx, 4'd6, M_READ | M_MDRIN | M_BUSY, c);
            end
            c++; push(idx, 4'd7, M_MDROUT | M_GRA | M_RIN | M_DONE | M_BUSY, c);
        end else begin
            c++; push(idx, 4'd6, M_GRA | M_BAOUT | M_MDRIN | M_BUSY, c);
            for (int i = 0; i <= w; i++) begin
                c++; push(idx, 4'd7, M_MDROUT | M_WRITE | M_BUSY | ((i == w) ? M_DONE : 22'h0), c);
            end
        end
    endtask

    // Call at a falling edge; returns at the next falling edge (T0 cycle)
    task automatic issue(input int idx, input logic [4:0] op, input int w, output int base);
        base = cyc;
        if (idx == 0) begin op0 = op; start0 = 1'b1; end
        else          begin op1 = op; start1 = 1'b1; end
        rd_cnt[idx]  = 0;
        inc_cnt[idx] = 0;
        rin_cnt[idx] = 0;
        push_instr(idx, op, w, base);
        @(negedge clk);
        if (idx == 0) start0 = 1'b0;
        else          start1 = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input string name);
        int n;
        n = 0;
        while ((((idx == 0) ? q0.size() : q1.size()) != 0 ||
                ((idx == 0) ? sig0[2] : sig1[2]) == 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic mon(input int idx, input logic [21:0] s, input logic [3:0] st);
        exp_t e;
        if ((s & M_DONE) != 0) begin
            done_cyc[idx] = cyc;
            done_cnt[idx]++;
            $display("txn dut%0d done at cycle %0d", idx, cyc);
        end
        if ((s & M_ILL) != 0) begin
            ill_cyc[idx] = cyc;
            $display("txn dut%0d illegal at cycle %0d", idx, cyc);
        end
        if ((s & M_READ) != 0)  rd_cnt[idx]++;
        if ((s & M_INCPC) != 0) inc_cnt[idx]++;
        if ((s & M_RIN) != 0)   rin_cnt[idx]++;
        if (s != 22'h0 || st != STEP_IDLE) begin
            n_checks++;
            if (((idx == 0) ? q0.size() : q1.size()) == 0) begin
                n_fail++;
                $display("FAIL dut%0d_unexpected cyc=%0d: got step=%0d sig=%h, required idle", idx, cyc, st, s);
            end else begin
                if (idx == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                if (e.step !== st || e.sig !== s || e.cyc !== cyc) begin
                    n_fail++;
                    $display("FAIL dut%0d_vector: got step=%0d sig=%h cyc=%0d, required step=%0d sig=%h cyc=%0d",
                             idx, st, s, cyc, e.step, e.sig, e.cyc);
                end
            end
        end
    endtask

    // Monitor: compare activity of both DUTs on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            mon(0, sig0, step0);
            mon(1, sig1, step1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         n;
        logic [4:0] t_op[3];
        int         t_lat[3];

        n_checks = 0;
        n_fail   = 0;
        clr      = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        op0      = 5'd0;
        op1      = 5'd0;
        for (int i = 0; i < 2; i++) begin
            done_cyc[i] = 0; done_cnt[i] = 0; ill_cyc[i] = 0;
            rd_cnt[i] = 0; inc_cnt[i] = 0; rin_cnt[i] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_sig0", int'(sig0), 0);
        check("reset_step0", int'(step0), 15);
        check("reset_sig1", int'(sig1), 0);
        check("reset_step1", int'(step1), 15);
        clr = 1'b0;
        @(negedge clk);

        // st, no wait states: done in cycle 8, one IncPC
        issue(0, OP_ST, 0, base);
        wait_idle(0, "st_w0");
        check("st_w0_done_cycle", done_cyc[0] - base, 8);
        check("st_w0_incpc", inc_cnt[0], 1);

        // ld, 2 wait states: Read 3+3 cycles, one IncPC, done in cycle 12.
        // A start pulse mid-instruction must be ignored.
        issue(1, OP_LD, 2, base);
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_idle(1, "ld_w2");
        check("ld_w2_done_cycle", done_cyc[1] - base, 12);
        check("ld_w2_read_cycles", rd_cnt[1], 6);
        check("ld_w2_incpc", inc_cnt[1], 1);

        // ldi, no wait states: done in cycle 6, Rin only in T5
        issue(0, OP_LDI, 0, base);
        wait_idle(0, "ldi_w0");
        check("ldi_w0_done_cycle", done_cyc[0] - base, 6);
        check("ldi_w0_rin_cycles", rin_cnt[0], 1);

        // Illegal opcode: pulse in cycle 4, then back to idle
        issue(0, 5'b11111, 0, base);
        wait_idle(0, "ill_w0");
        check("ill_w0_cycle", ill_cyc[0] - base, 4);

        // Wait-state table on the MEM_WAIT=2 instance
        t_op[0] = OP_LDI;  t_lat[0] = 8;
        t_op[1] = OP_ST;   t_lat[1] = 12;
        t_op[2] = 5'b10101; t_lat[2] = 6;
        for (int k = 0; k < 3; k++) begin
            issue(1, t_op[k], 2, base);
            wait_idle(1, "table_w2");
            if (k == 2) check("table_w2_ill_cycle", ill_cyc[1] - base, t_lat[k]);
            else        check("table_w2_done_cycle", done_cyc[1] - base, t_lat[k]);
        end

        // clr in T4 of an st; a simultaneous start on the other DUT loses
        issue(0, OP_ST, 0, base);
        n = 0;
        while (step0 != 4'd4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("clr_reach_t4", int'(step0), 4);
        #2;
        clr    = 1'b1;
        start1 = 1'b1;
        #1;
        check("clr_async_sig0", int'(sig0), 0);
        check("clr_async_step0", int'(step0), 15);
        q0.delete();
        @(negedge clk);
        clr    = 1'b0;
        start1 = 1'b0;
        check("clr_wins_start_step1", int'(step1), 15);
        @(negedge clk);
        issue(0, OP_ST, 0, base);
        wait_idle(0, "st_after_clr");
        check("st_after_clr_done_cycle", done_cyc[0] - base, 8);

        // start held high: three ldi back to back, one IDLE cycle between
        done_cnt[0] = 0;
        base   = cyc;
        op0    = OP_LDI;
        start0 = 1'b1;
        push_instr(0, OP_LDI, 0, base);
        push_instr(0, OP_LDI, 0, base + 7);
        push_instr(0, OP_LDI, 0, base + 14);
        repeat (20) @(negedge clk);
        start0 = 1'b0;
        wait_idle(0, "held_start");
        check("held_start_done_count", done_cnt[0], 3);
        check("held_start_last_done", done_cyc[0] - base, 20);

        repeat (4) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
